// File: rtl/stream_mux_rr.sv
// Round-robin N:1 valid/ready stream mux with a registered output stage.
// Define STREAM_MUX_RR_LOCK_EN to hold the grant on one channel until its packet ends.
module stream_mux_rr #(
  parameter int width_p = 8,
  parameter int channels_p = 4,
  localparam int sel_width_lp = $clog2(channels_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [channels_p-1:0]         valid_i,
  output logic [channels_p-1:0]         ready_o,
  input  logic [channels_p*width_p-1:0] data_i,
  input  logic [channels_p-1:0]         last_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [width_p-1:0]            data_o,
  output logic                          last_o,
  output logic [sel_width_lp-1:0]       sel_o
);

  logic [sel_width_lp-1:0] ptr_q;
  logic [sel_width_lp-1:0] grant;
  logic [sel_width_lp-1:0] cand;
  logic                    grant_valid;
  logic                    accept_en;
  logic                    in_xfer;
  logic [channels_p-1:0]   eligible;
  logic [width_p-1:0]      data_sel;
  logic                    last_sel;

`ifdef STREAM_MUX_RR_LOCK_EN
  logic                    lock_q;
  logic [sel_width_lp-1:0] lock_ch_q;

  // While a packet is open only the locked channel may compete, even if it is idle.
  always_comb begin
    eligible = '0;
    if (lock_q) begin
      eligible[lock_ch_q] = valid_i[lock_ch_q];
    end else begin
      eligible = valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (in_xfer) begin
      lock_q    <= !last_sel;
      lock_ch_q <= grant;
    end
  end
`else
  assign eligible = valid_i;
`endif

  // Search starts one past the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int i = 0; i < channels_p; i++) begin
      cand = sel_width_lp'((int'(ptr_q) + 1 + i) % channels_p);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    last_sel = 1'b0;
    for (int k = 0; k < channels_p; k++) begin
      if (grant == sel_width_lp'(k)) begin
        data_sel = data_i[k*width_p +: width_p];
        last_sel = last_i[k];
      end
    end
  end

  assign accept_en = !valid_o || ready_i;
  assign in_xfer   = grant_valid && accept_en;

  always_comb begin
    ready_o = '0;
    if (reset_ni && grant_valid) begin
      ready_o[grant] = accept_en;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      sel_o   <= '0;
      ptr_q   <= sel_width_lp'(channels_p - 1);
    end else if (in_xfer) begin
      valid_o <= 1'b1;
      data_o  <= data_sel;
      last_o  <= last_sel;
      sel_o   <= grant;
      ptr_q   <= grant;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: vector tables applied per cycle, expected output beats queued
// when each vector is driven and compared once the registered output has updated.
module tb_stream_mux_rr;

  localparam int W = 8;
  localparam int C = 4;

  logic           clk_i = 1'b0;
  logic           reset_ni;
  logic [C-1:0]   valid_i;
  logic [C-1:0]   ready_o;
  logic [C*W-1:0] data_i;
  logic [C-1:0]   last_i;
  logic           valid_o;
  logic           ready_i;
  logic [W-1:0]   data_o;
  logic           last_o;
  logic [1:0]     sel_o;

  typedef struct {
    logic [C-1:0]   valid;
    logic [C*W-1:0] data;
    logic [C-1:0]   last;
    logic           rdy;
    logic [C-1:0]   exp_ready;
    logic           exp_valid;
    logic [W-1:0]   exp_data;
    logic           exp_last;
    logic [1:0]     exp_sel;
  } vec_t;

  typedef struct {
    logic         valid;
    logic [W-1:0] data;
    logic         last;
    logic [1:0]   sel;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb_q[$];
  int    checks = 0;
  int    fails  = 0;

  localparam logic [C*W-1:0] DATA_A = 32'hA3A2A1A0;

  always #5 clk_i = ~clk_i;

  stream_mux_rr #(.width_p(W), .channels_p(C)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .last_o(last_o), .sel_o(sel_o)
  );

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [C-1:0] v, input logic [C*W-1:0] d, input logic [C-1:0] l,
                         input logic r, input logic [C-1:0] er, input logic ev,
                         input logic [W-1:0] ed, input logic el, input logic [1:0] es);
    vec_t x;
    x.valid = v; x.data = d; x.last = l; x.rdy = r;
    x.exp_ready = er; x.exp_valid = ev; x.exp_data = ed; x.exp_last = el; x.exp_sel = es;
    vecs.push_back(x);
  endtask

  // Called just after a falling edge: drive inputs, check the combinational grant, queue the beat.
  task automatic applyStimulus(input vec_t v);
    beat_t b;
    valid_i = v.valid;
    data_i  = v.data;
    last_i  = v.last;
    ready_i = v.rdy;
    #1;
    compare("ready_o", 32'(ready_o), 32'(v.exp_ready));
    b.valid = v.exp_valid; b.data = v.exp_data; b.last = v.exp_last; b.sel = v.exp_sel;
    sb_q.push_back(b);
  endtask

  task automatic checkOutput();
    beat_t b;
    @(negedge clk_i);
    if (sb_q.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard: got empty queue, expected a beat");
    end else begin
      b = sb_q.pop_front();
      compare("valid_o", 32'(valid_o), 32'(b.valid));
      compare("data_o",  32'(data_o),  32'(b.data));
      compare("last_o",  32'(last_o),  32'(b.last));
      compare("sel_o",   32'(sel_o),   32'(b.sel));
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    reset_ni = 1'b0;
    valid_i  = '0;
    data_i   = '0;
    last_i   = '0;
    ready_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    valid_i = 4'b1111;
    #1;
    compare("ready_o in reset", 32'(ready_o), 32'h0);
    valid_i = '0;
    reset_ni = 1'b1;
    #1;
    compare("reset valid_o", 32'(valid_o), 32'h0);
    compare("reset data_o",  32'(data_o),  32'h0);
    compare("reset last_o",  32'(last_o),  32'h0);
    compare("reset sel_o",   32'(sel_o),   32'h0);
    compare("reset ready_o", 32'(ready_o), 32'h0);
    @(negedge clk_i);

    $display("[TB] round robin over all channels, then backpressure");
    add_vec(4'b1111, DATA_A, 4'b0, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b0, 2'd0);
    add_vec(4'b1111, DATA_A, 4'b0, 1'b1, 4'b0010, 1'b1, 8'hA1, 1'b0, 2'd1);
    add_vec(4'b1111, DATA_A, 4'b0, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b0, 2'd2);
    add_vec(4'b1111, DATA_A, 4'b0, 1'b1, 4'b1000, 1'b1, 8'hA3, 1'b0, 2'd3);
    add_vec(4'b1111, DATA_A, 4'b0, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++)
      add_vec(4'b1111, DATA_A, 4'b0, 1'b0, 4'b0000, 1'b1, 8'hA0, 1'b0, 2'd0);
    add_vec(4'b1111, DATA_A, 4'b0, 1'b1, 4'b0010, 1'b1, 8'hA1, 1'b0, 2'd1);
    add_vec(4'b0000, '0,     4'b0, 1'b1, 4'b0000, 1'b0, 8'hA1, 1'b0, 2'd1);
    run_table();

    $display("[TB] asynchronous reset with a beat pending");
    add_vec(4'b1111, DATA_A, 4'b0, 1'b1, 4'b0100, 1'b1, 8'hA2, 1'b0, 2'd2);
    run_table();
    #2;
    reset_ni = 1'b0;
    #1;
    compare("midreset valid_o", 32'(valid_o), 32'h0);
    compare("midreset data_o",  32'(data_o),  32'h0);
    compare("midreset sel_o",   32'(sel_o),   32'h0);
    compare("midreset last_o",  32'(last_o),  32'h0);
    compare("midreset ready_o", 32'(ready_o), 32'h0);
    sb_q.delete();
    @(negedge clk_i);
    reset_ni = 1'b1;
    add_vec(4'b1111, DATA_A, 4'b0, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b0, 2'd0);
    add_vec(4'b0000, '0,     4'b0, 1'b1, 4'b0000, 1'b0, 8'hA0, 1'b0, 2'd0);
    run_table();

    $display("[TB] single channel streaming, then wrap-around");
    add_vec(4'b0100, 32'h00110000, 4'b0, 1'b1, 4'b0100, 1'b1, 8'h11, 1'b0, 2'd2);
    add_vec(4'b0100, 32'h00220000, 4'b0, 1'b1, 4'b0100, 1'b1, 8'h22, 1'b0, 2'd2);
    add_vec(4'b0100, 32'h00330000, 4'b0, 1'b1, 4'b0100, 1'b1, 8'h33, 1'b0, 2'd2);
    add_vec(4'b0000, '0,           4'b0, 1'b1, 4'b0000, 1'b0, 8'h33, 1'b0, 2'd2);
    add_vec(4'b1000, 32'h44000000, 4'b0, 1'b1, 4'b1000, 1'b1, 8'h44, 1'b0, 2'd3);
    add_vec(4'b1001, 32'h44000055, 4'b0, 1'b1, 4'b0001, 1'b1, 8'h55, 1'b0, 2'd0);
    add_vec(4'b0000, '0,           4'b0, 1'b1, 4'b0000, 1'b0, 8'h55, 1'b0, 2'd0);
    run_table();

    $display("[TB] packet from channel 1 competing with channel 2");
`ifdef STREAM_MUX_RR_LOCK_EN
    add_vec(4'b0110, 32'h00706100, 4'b0100, 1'b1, 4'b0010, 1'b1, 8'h61, 1'b0, 2'd1);
    add_vec(4'b0100, 32'h00700000, 4'b0100, 1'b1, 4'b0000, 1'b0, 8'h61, 1'b0, 2'd1);
    add_vec(4'b0110, 32'h00706200, 4'b0100, 1'b1, 4'b0010, 1'b1, 8'h62, 1'b0, 2'd1);
    add_vec(4'b0110, 32'h00706300, 4'b0110, 1'b1, 4'b0010, 1'b1, 8'h63, 1'b1, 2'd1);
    add_vec(4'b0100, 32'h00700000, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h70, 1'b1, 2'd2);
    add_vec(4'b0000, '0,           4'b0000, 1'b1, 4'b0000, 1'b0, 8'h70, 1'b1, 2'd2);
`else
    add_vec(4'b0110, 32'h00706100, 4'b0100, 1'b1, 4'b0010, 1'b1, 8'h61, 1'b0, 2'd1);
    add_vec(4'b0110, 32'h00706200, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h70, 1'b1, 2'd2);
    add_vec(4'b0110, 32'h00706200, 4'b0100, 1'b1, 4'b0010, 1'b1, 8'h62, 1'b0, 2'd1);
    add_vec(4'b0110, 32'h00706300, 4'b0110, 1'b1, 4'b0100, 1'b1, 8'h70, 1'b1, 2'd2);
    add_vec(4'b0110, 32'h00706300, 4'b0110, 1'b1, 4'b0010, 1'b1, 8'h63, 1'b1, 2'd1);
    add_vec(4'b0000, '0,           4'b0000, 1'b1, 4'b0000, 1'b0, 8'h63, 1'b1, 2'd1);
`endif
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
